// File: rtl/instr_fetch_unit_pkg.sv
// Shared processor definitions for the fetch stage: FSM encoding, instruction width, HLT opcode.
package instr_fetch_unit_pkg;

    localparam int INSTR_WIDTH = 16;
    localparam logic [3:0] HLT_OPCODE = 4'hF;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_pc_register.sv
// Program counter: sync reset to RESET_PC, redirect load (bit 0 cleared) beats +2 advance, else hold.
// Single-cycle update; the caller deasserts both controls to hold.
module pc_register #(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect,
    input  logic                  advance,
    input  logic [ADDR_WIDTH-1:0] target,
    output logic [ADDR_WIDTH-1:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= target & ~ADDR_WIDTH'(1);
        end else if (advance) begin
            pc <= pc + ADDR_WIDTH'(2);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: drives the imem read port from the PC and registers each word for decode.
// Latency: word at pc appears on instr_out one edge after it is addressed in FETCH.
// Backpressure: stall holds PC and instruction register; redirect overrides stall and squashes.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [3:0]            HALT_OPCODE = HLT_OPCODE
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    output logic                   imem_en,
    output logic                   imem_wr,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic [ADDR_WIDTH-1:0]  instr_pc_plus2,
    output logic                   instr_valid,
    output logic                   halted
);

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  fetching;
    logic                  is_halt;
    logic                  pc_redirect;
    logic                  pc_advance;

    assign fetching    = (state == FETCH);
    assign is_halt     = (imem_rdata[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);
    assign pc_redirect = fetching && redirect_valid;
    // A fetched HLT freezes the PC at its own address.
    assign pc_advance  = fetching && !redirect_valid && !stall && !is_halt;

    assign imem_addr  = pc;
    assign imem_wr    = 1'b0;
    assign imem_wdata = '0;

    pc_register #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .redirect (pc_redirect),
        .advance  (pc_advance),
        .target   (redirect_pc),
        .pc       (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= BOOT;
            imem_en        <= 1'b0;
            halted         <= 1'b0;
            instr_out      <= '0;
            instr_pc       <= '0;
            instr_pc_plus2 <= '0;
            instr_valid    <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state   <= FETCH;
                    imem_en <= 1'b1;
                end
                FETCH: begin
                    if (redirect_valid) begin
                        instr_valid <= 1'b0;
                    end else if (!stall) begin
                        instr_out      <= imem_rdata;
                        instr_pc       <= pc;
                        instr_pc_plus2 <= pc + ADDR_WIDTH'(2);
                        instr_valid    <= 1'b1;
                        if (is_halt) begin
                            state   <= HALTED;
                            imem_en <= 1'b0;
                            halted  <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state   <= BOOT;
                    imem_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, hand-written corner sequences, randomized run vs. model.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic [15:0] imem_addr;
    logic        imem_en;
    logic        imem_wr;
    logic [15:0] imem_wdata;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [15:0] instr_out;
    logic [15:0] instr_pc;
    logic [15:0] instr_pc_plus2;
    logic        instr_valid;
    logic        halted;

    logic [15:0] mem [0:32767];

    int total = 0;
    int bad   = 0;

    // Reference model state, kept as plain flags and numbers.
    bit          m_boot;
    bit          m_halt;
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_ipc;
    logic [15:0] m_p2;
    bit          m_valid;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_en        (imem_en),
        .imem_wr        (imem_wr),
        .imem_wdata     (imem_wdata),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .instr_pc_plus2 (instr_pc_plus2),
        .instr_valid    (instr_valid),
        .halted         (halted)
    );

    assign imem_rdata = mem[imem_addr[15:1]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic s, input logic rv, input logic [15:0] rpc);
        logic [15:0] w;
        if (r) begin
            m_boot = 1; m_halt = 0; m_pc = 16'h0000;
            m_instr = 0; m_ipc = 0; m_p2 = 0; m_valid = 0;
        end else if (m_boot) begin
            m_boot = 0;
        end else if (!m_halt) begin
            if (rv) begin
                m_pc = {rpc[15:1], 1'b0};
                m_valid = 0;
            end else if (!s) begin
                w = mem[m_pc / 2];
                m_instr = w;
                m_ipc = m_pc;
                m_p2 = 16'((32'(m_pc) + 2) % 65536);
                m_valid = 1;
                if (w[15:12] == 4'hF) m_halt = 1;
                else m_pc = 16'((32'(m_pc) + 2) % 65536);
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic rv, input logic [15:0] rpc);
        rst = r; stall = s; redirect_valid = rv; redirect_pc = rpc;
        @(posedge clk);
        model_edge(r, s, rv, rpc);
        #1;
        chk("en",     {31'd0, imem_en},     {31'd0, !m_boot && !m_halt});
        chk("addr",   {16'd0, imem_addr},   {16'd0, m_pc});
        chk("valid",  {31'd0, instr_valid}, {31'd0, m_valid});
        chk("instr",  {16'd0, instr_out},   {16'd0, m_instr});
        chk("ipc",    {16'd0, instr_pc},    {16'd0, m_ipc});
        chk("ipc2",   {16'd0, instr_pc_plus2}, {16'd0, m_p2});
        chk("halted", {31'd0, halted},      {31'd0, m_halt});
        chk("wr",     {31'd0, imem_wr},     32'd0);
        chk("wdata",  {16'd0, imem_wdata},  32'd0);
    endtask

    typedef struct {
        logic        r, s, rv;
        logic [15:0] rpc;
        logic        e_en, e_valid, e_halt;
        logic [15:0] e_addr, e_instr, e_ipc, e_p2;
    } vec_t;

    vec_t vecs [15];

    initial begin
        rst = 1; stall = 0; redirect_valid = 0; redirect_pc = 0;
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'hF000;
        mem[16'h40 / 2] = 16'h5555; mem[16'h42 / 2] = 16'h6666;
        mem[16'h10 / 2] = 16'h7777; mem[16'h12 / 2] = 16'h1234;
        mem[16'hFFFE / 2] = 16'h4444;

        //           r  s  rv rpc      en valid halt addr     instr    ipc      p2
        vecs[0]  = '{1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[1]  = '{1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[2]  = '{0, 0, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[3]  = '{0, 0, 0, 16'h0000, 1, 1, 0, 16'h0002, 16'h1111, 16'h0000, 16'h0002};
        vecs[4]  = '{0, 0, 0, 16'h0000, 1, 1, 0, 16'h0004, 16'h2222, 16'h0002, 16'h0004};
        vecs[5]  = '{0, 1, 0, 16'h0000, 1, 1, 0, 16'h0004, 16'h2222, 16'h0002, 16'h0004};
        vecs[6]  = '{0, 1, 0, 16'h0000, 1, 1, 0, 16'h0004, 16'h2222, 16'h0002, 16'h0004};
        vecs[7]  = '{0, 1, 0, 16'h0000, 1, 1, 0, 16'h0004, 16'h2222, 16'h0002, 16'h0004};
        vecs[8]  = '{0, 0, 0, 16'h0000, 1, 1, 0, 16'h0006, 16'h3333, 16'h0004, 16'h0006};
        vecs[9]  = '{0, 1, 1, 16'h0041, 1, 0, 0, 16'h0040, 16'h3333, 16'h0004, 16'h0006};
        vecs[10] = '{0, 0, 0, 16'h0000, 1, 1, 0, 16'h0042, 16'h5555, 16'h0040, 16'h0042};
        vecs[11] = '{0, 0, 1, 16'h0006, 1, 0, 0, 16'h0006, 16'h5555, 16'h0040, 16'h0042};
        vecs[12] = '{0, 0, 0, 16'h0000, 0, 1, 1, 16'h0006, 16'hF000, 16'h0006, 16'h0008};
        vecs[13] = '{0, 0, 1, 16'h0000, 0, 1, 1, 16'h0006, 16'hF000, 16'h0006, 16'h0008};
        vecs[14] = '{0, 1, 1, 16'h0020, 0, 1, 1, 16'h0006, 16'hF000, 16'h0006, 16'h0008};

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].r, vecs[i].s, vecs[i].rv, vecs[i].rpc);
            chk($sformatf("row%0d_en", i),     {31'd0, imem_en},     {31'd0, vecs[i].e_en});
            chk($sformatf("row%0d_valid", i),  {31'd0, instr_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("row%0d_halted", i), {31'd0, halted},      {31'd0, vecs[i].e_halt});
            chk($sformatf("row%0d_addr", i),   {16'd0, imem_addr},   {16'd0, vecs[i].e_addr});
            chk($sformatf("row%0d_instr", i),  {16'd0, instr_out},   {16'd0, vecs[i].e_instr});
            chk($sformatf("row%0d_ipc", i),    {16'd0, instr_pc},    {16'd0, vecs[i].e_ipc});
            chk($sformatf("row%0d_ipc2", i),   {16'd0, instr_pc_plus2}, {16'd0, vecs[i].e_p2});
        end

        // Wrap-around from 0xFFFE.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 16'hFFFF);
        chk("wrap_addr_pre", {16'd0, imem_addr}, 32'h0000FFFE);
        step(0, 0, 0, 0);
        chk("wrap_instr", {16'd0, instr_out},      32'h00004444);
        chk("wrap_ipc",   {16'd0, instr_pc},       32'h0000FFFE);
        chk("wrap_ipc2",  {16'd0, instr_pc_plus2}, 32'h00000000);
        chk("wrap_addr",  {16'd0, imem_addr},      32'h00000000);

        // Reset mid-run while fetching at 0x0010.
        step(0, 0, 1, 16'h0010);
        step(0, 0, 0, 0);
        chk("mid_pc", {16'd0, imem_addr}, 32'h00000012);
        step(0, 0, 1, 16'h0010);
        chk("mid_pc_at10", {16'd0, imem_addr}, 32'h00000010);
        step(1, 0, 0, 0);
        chk("mid_rst_valid",  {31'd0, instr_valid}, 32'd0);
        chk("mid_rst_halted", {31'd0, halted},      32'd0);
        chk("mid_rst_en",     {31'd0, imem_en},     32'd0);
        chk("mid_rst_addr",   {16'd0, imem_addr},   32'd0);
        step(0, 0, 0, 0);
        chk("mid_boot_en", {31'd0, imem_en}, 32'd1);
        step(0, 0, 0, 0);
        chk("mid_first", {16'd0, instr_out}, 32'h00001111);

        // Randomized run against the model.
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        step(1, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            logic r, s, rv;
            r  = ($urandom_range(99) < 2) || (m_halt && $urandom_range(7) == 0);
            s  = ($urandom_range(3) == 0);
            rv = ($urandom_range(9) == 0);
            step(r, s, rv, 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
